i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  I2S master transmitter, the transmit counterpart of the I2S receiver. Generates BCLK and WS
//  from the system clock and serialises stereo frames onto DOUT in Philips I2S format (MSB first,
//  one BCLK after each WS edge). Takes L/R samples from the SoC side over a valid/ready handshake
//  through a one-deep holding buffer. Zero-fills on underrun.
// PARAMETERS
//  CLK_DIV   8   system clocks per BCLK half-period (>=1)
//  SAMPLE_W  24  sample width per channel (1..SLOT_W)
//  SLOT_W    32  BCLK periods per channel slot; frame = 2*SLOT_W BCLKs
// PORTS
//  clk       in   1         system clock
//  rst       in   1         async reset, active-high
//  en        in   1         run request
//  in_l      in   SAMPLE_W  left sample
//  in_r      in   SAMPLE_W  right sample
//  in_valid  in   1         sample pair valid
//  in_ready  out  1         holding buffer empty; transfer when in_valid & in_ready at posedge clk
//  BCLK      out  1         bit clock
//  WS        out  1         word select, 0 = left, 1 = right
//  DOUT      out  1         serial data
//  busy      out  1         high in RUN or STOP
//  underrun  out  1         1-clk pulse when a frame loads with the buffer empty
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): BCLK=0, WS=0, DOUT=0, busy=0, underrun=0,
//    in_ready=1. Buffer and shift register cleared. State=IDLE.
//  - Divider: div_cnt counts 0..CLK_DIV-1. At terminal count BCLK toggles.
//    A 1->0 toggle is a "fall event". All WS and DOUT changes happen only on fall events.
//  - bit_cnt 0..2*SLOT_W-1 advances on each fall event and wraps to 0.
//    WS = (bit_cnt >= SLOT_W).
//  - frame[2*SLOT_W-1:0] = {in_l, pad zeros, in_r, pad zeros}, each slot SLOT_W bits, MSB first.
//    DOUT during bit_cnt=k is frame[2*SLOT_W-1-(k-1)] for k>=1.
//    During k=0, DOUT is the previous frame's bit 0 (registered 1-bit delay).
//  - Frame load happens on RUN entry and on each fall event where bit_cnt wraps to 0.
//    If the buffer is full: buffer -> frame, and in_ready=1 on the next clk.
//    If the buffer is empty: frame = 0, and underrun pulses for exactly 1 clk.
//  - Handshake: in_ready is a registered buffer-empty flag.
//    Accept in the same cycle as a load of an empty buffer: the load counts as underrun,
//    and the accepted pair goes to the next frame.
//    in_valid while in_ready=0 is ignored, with no overwrite.
//  - FSM:
//    IDLE: BCLK=0, WS=0, DOUT=0. On en=1 -> RUN with div_cnt=0, bit_cnt=0, frame loaded.
//      First BCLK rise comes CLK_DIV clks later. First fall (bit_cnt=1, MSB of L) comes 2*CLK_DIV clks later.
//    RUN: free-running. At a wrap-to-0 fall event with en=0 -> STOP, with no load.
//      en changes mid-frame have no effect until the wrap.
//    STOP: drives the final bit period (bit_cnt=0). At the next fall event -> IDLE, DOUT=0.
//      en=1 in STOP is ignored until IDLE.
//  - Buffer contents survive IDLE. Only rst clears them.
// STRUCTURE
//  - i2s_pkg: FSM state encoding, FRAME_W = 2*SLOT_W.
//    It is shared with the receiver for slot/frame constants.
//  - Sub-module i2s_clkgen: the CLK_DIV divider, outputting BCLK plus rise/fall 1-clk strobes.
//    It is reusable by the receiver.
//  - Top level: holding buffer, shift register, bit counter, FSM.
// TESTING
//  1 Hold rst=1, toggle in_valid/en -> BCLK=WS=DOUT=busy=underrun=0, in_ready=1.
//    Assert rst mid-frame -> same values within the cycle.
//  2 CLK_DIV=2, L=24'hA5A5A5, R=24'h123456, then en=1:
//    - WS low 32 BCLKs then high 32 BCLKs.
//    - DOUT: 1 BCLK delay, then A5A5A5 and 8 zeros, then 123456 and 8 zeros.
//    - Loopback into the receiver yields the same pair.
//  3 en=1 with no in_valid -> DOUT=0 for every bit, underrun pulses once per frame (64 BCLKs), busy=1.
//  4 Stream 3 pairs with in_valid held -> each accepted exactly once, 3 gapless frames in order,
//    in_ready low between loads, no underrun until after frame 3.
//  5 Drop en at bit_cnt=10 -> frame completes, final bit driven, then IDLE with BCLK=0.
//    Total BCLK count = 64 + 1.
//  6 Load at wrap coincides with in_valid on an empty buffer -> underrun pulse, zero frame,
//    and the pair is sent in the following frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S transmitter and receiver:
//   - i2s_state_t : transmitter FSM state encoding
//   - DEF_*       : default clocking / slot geometry
//   - frame_w()   : frame length in BCLKs for a given slot width
//   - cnt_w()     : register width needed to count 0..n-1
// -----------------------------------------------------------------------------
package i2s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // serial lines parked low, divider stopped
      ST_RUN  = 2'd1,   // free-running frames
      ST_STOP = 2'd2    // driving the trailing bit of the last frame
   } i2s_state_t;

   localparam int DEF_CLK_DIV  = 8;
   localparam int DEF_SAMPLE_W = 24;
   localparam int DEF_SLOT_W   = 32;
   localparam int DEF_FRAME_W  = 2 * DEF_SLOT_W;

   // One frame carries a left slot followed by a right slot.
   function automatic int frame_w(input int slot_w);
      return 2 * slot_w;
   endfunction

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if
// Sample-pair handshake between the SoC and the I2S transmitter.
//   l, r   : left / right sample (SAMPLE_W bits)
//   valid  : sample pair valid (source -> transmitter)
//   ready  : transmitter holding buffer empty (transmitter -> source)
// A pair transfers when valid & ready are both high at a rising clock edge.
//   master : SoC side (drives data and valid)
//   slave  : transmitter side (drives ready)
// -----------------------------------------------------------------------------
interface i2s_tx_if
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W
);

   logic [SAMPLE_W-1:0] l;
   logic [SAMPLE_W-1:0] r;
   logic                valid;
   logic                ready;

   modport master (output l, output r, output valid, input ready);
   modport slave  (input l, input r, input valid, output ready);

endinterface

// File: rtl/i2s_clkgen.sv
// -----------------------------------------------------------------------------
// i2s_clkgen
// Bit-clock generator. While i_run is high a divider counts 0..CLK_DIV-1 and
// BCLK toggles at each terminal count, so one BCLK period is 2*CLK_DIV clocks.
// While i_run is low the divider is held at zero and BCLK is parked low, so the
// first rise comes CLK_DIV clocks after i_run goes high.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active-high
//   i_run   in   divider enable
//   o_bclk  out  bit clock
//   o_rise  out  high in the cycle whose closing edge takes BCLK 0->1
//   o_fall  out  high in the cycle whose closing edge takes BCLK 1->0
// The strobes are combinational so that logic clocked by clk can update in
// the same edge that moves BCLK.
// -----------------------------------------------------------------------------
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)(
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   output logic o_bclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int            DW = cnt_w(CLK_DIV);
   localparam logic [DW-1:0] TC = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div_cnt;
   logic          r_bclk;
   logic          w_tc;

   assign w_tc = i_run && (r_div_cnt == TC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
      end else if (!i_run) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
      end else if (w_tc) begin
         r_div_cnt <= '0;
         r_bclk    <= ~r_bclk;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   assign o_bclk = r_bclk;
   assign o_rise = w_tc & ~r_bclk;
   assign o_fall = w_tc &  r_bclk;

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// I2S master transmitter (Philips format). Generates BCLK/WS from clk and
// shifts stereo frames out MSB first, one BCLK after each WS edge. Sample
// pairs arrive over a valid/ready handshake into a one-deep holding buffer;
// a frame that loads while the buffer is empty is sent as zeros and flagged
// with a one-clock underrun pulse.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   i_en        in   run request (sampled only in IDLE and at frame wrap)
//   s_if        --   sample handshake (slave modport: l, r, valid in; ready out)
//   o_bclk      out  bit clock
//   o_ws        out  word select, 0 = left slot, 1 = right slot
//   o_dout      out  serial data
//   o_busy      out  high in RUN or STOP
//   o_underrun  out  one-clock pulse when a frame loads from an empty buffer
//
// Frame layout (FRAME_W = 2*SLOT_W bits, MSB first):
//   {left sample, zero pad, right sample, zero pad}
// During bit_cnt = k >= 1 DOUT carries frame[FRAME_W-k]; during k = 0 it
// still carries bit 0 of the previous frame (the one-BCLK I2S delay).
// -----------------------------------------------------------------------------
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int SLOT_W   = DEF_SLOT_W
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_en,
   i2s_tx_if.slave   s_if,
   output logic      o_bclk,
   output logic      o_ws,
   output logic      o_dout,
   output logic      o_busy,
   output logic      o_underrun
);

   localparam int             FRAME_W    = frame_w(SLOT_W);
   localparam int             BCW        = cnt_w(FRAME_W);
   localparam int             PAD        = SLOT_W - SAMPLE_W;
   localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_W - 1);
   localparam logic [BCW-1:0] SLOT_START = BCW'(SLOT_W);

   i2s_state_t           r_state;
   i2s_state_t           w_state_nxt;
   logic [BCW-1:0]       r_bit_cnt;
   logic [BCW-1:0]       w_bit_nxt;
   logic [FRAME_W-1:0]   r_shreg;
   logic [SAMPLE_W-1:0]  r_buf_l;
   logic [SAMPLE_W-1:0]  r_buf_r;
   logic                 r_full;
   logic                 r_ws;
   logic                 r_dout;
   logic                 r_underrun;

   logic                 w_run;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_wrap;
   logic                 w_load;
   logic                 w_accept;
   logic [SLOT_W-1:0]    w_slot_l;
   logic [SLOT_W-1:0]    w_slot_r;
   logic [FRAME_W-1:0]   w_frame;

   assign w_run = (r_state != ST_IDLE);

   i2s_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk    (clk),
      .rst    (rst),
      .i_run  (w_run),
      .o_bclk (o_bclk),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_wrap    = (r_bit_cnt == LAST_BIT);
   assign w_bit_nxt = w_wrap ? '0 : r_bit_cnt + 1'b1;

   // Samples sit left-justified in their slot, zero padded below.
   assign w_slot_l = SLOT_W'(r_buf_l) << PAD;
   assign w_slot_r = SLOT_W'(r_buf_r) << PAD;
   assign w_frame  = {w_slot_l, w_slot_r};

   // ready is just the registered empty flag, so a full buffer is never
   // overwritten and acceptance never depends on a same-cycle load.
   assign w_accept   = s_if.valid & ~r_full;
   assign s_if.ready = ~r_full;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end
         end
         ST_RUN: begin
            // en is only looked at on the frame boundary.
            if (w_fall && w_wrap) begin
               if (i_en) w_load      = 1'b1;
               else      w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (w_fall) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Bit counter, WS and DOUT: all change on BCLK fall events only.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
         r_ws      <= 1'b0;
         r_dout    <= 1'b0;
      end else if (r_state == ST_STOP && w_fall) begin
         r_bit_cnt <= '0;
         r_ws      <= 1'b0;
         r_dout    <= 1'b0;
      end else if (r_state == ST_RUN && w_fall) begin
         r_bit_cnt <= w_bit_nxt;
         r_ws      <= (w_bit_nxt >= SLOT_START);
         r_dout    <= r_shreg[FRAME_W-1];
      end
   end

   // ---------------------------------------------------------------------
   // Shift register. The shift happens on the BCLK rise in the middle of a
   // bit so the next bit is already at the MSB when the fall samples it.
   // No shift during bit 0: the freshly loaded MSB is the next bit out.
   // At a wrap fall the outgoing bit 0 is read before the reload lands.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '0;
      end else if (w_load) begin
         r_shreg <= r_full ? w_frame : '0;
      end else if (r_state == ST_RUN && w_rise && r_bit_cnt != '0) begin
         r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
      end
   end

   // ---------------------------------------------------------------------
   // Holding buffer. An accept can coincide with a load only when the
   // buffer was empty: that load is an underrun and the new pair waits for
   // the following frame.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_l    <= '0;
         r_buf_r    <= '0;
         r_full     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_load & ~r_full;
         if (w_accept) begin
            r_buf_l <= s_if.l;
            r_buf_r <= s_if.r;
            r_full  <= 1'b1;
         end else if (w_load) begin
            r_full  <= 1'b0;
         end
      end
   end

   assign o_ws       = r_ws;
   assign o_dout     = r_dout;
   assign o_busy     = w_run;
   assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx. A time-based reference model (clock counts
// since RUN entry, frame = 64 bit periods) predicts buffer state, underrun
// pulses and the frame sequence; a negedge monitor acts as an I2S receiver,
// reassembles frames from DOUT at BCLK rises and pops expected frames.
module tb_i2s_tx;

   localparam int CLK_DIV    = 2;
   localparam int SAMPLE_W   = 24;
   localparam int SLOT_W     = 32;
   localparam int FW         = 2 * SLOT_W;
   localparam int BIT_CLKS   = 2 * CLK_DIV;
   localparam int FRAME_CLKS = FW * BIT_CLKS;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic bclk, ws, dout, busy, underrun;

   i2s_tx_if #(.SAMPLE_W(SAMPLE_W)) sif();

   i2s_tx #(
      .CLK_DIV  (CLK_DIV),
      .SAMPLE_W (SAMPLE_W),
      .SLOT_W   (SLOT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_en       (en),
      .s_if       (sif),
      .o_bclk     (bclk),
      .o_ws       (ws),
      .o_dout     (dout),
      .o_busy     (busy),
      .o_underrun (underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum logic [1:0] {M_IDLE, M_RUN, M_STOP} mstate_t;
   mstate_t             m_state   = M_IDLE;
   int                  m_cyc     = 0;
   bit                  m_full    = 1'b0;
   bit                  m_und     = 1'b0;
   int                  m_acc_cnt = 0;
   int                  m_run_id  = 0;
   logic [SAMPLE_W-1:0] m_l, m_r;
   logic [FW-1:0]       exp_q[$];

   function automatic logic [FW-1:0] make_frame(input logic [SAMPLE_W-1:0] l,
                                                 input logic [SAMPLE_W-1:0] r);
      logic [FW-1:0] lw, rw;
      lw = FW'(l);
      rw = FW'(r);
      return (lw << (FW - SAMPLE_W)) | (rw << (SLOT_W - SAMPLE_W));
   endfunction

   always @(posedge clk) begin : model
      bit load, acc;
      if (rst) begin
         m_state = M_IDLE;
         m_full  = 1'b0;
         m_und   = 1'b0;
         m_cyc   = 0;
         exp_q.delete();
      end else begin
         load  = 1'b0;
         acc   = sif.valid && !m_full;
         m_und = 1'b0;
         case (m_state)
            M_IDLE: if (en) begin
               m_state = M_RUN;
               m_cyc   = 0;
               load    = 1'b1;
               m_run_id++;
            end
            M_RUN: begin
               m_cyc++;
               if (m_cyc % FRAME_CLKS == 0) begin
                  if (en) load = 1'b1;
                  else    m_state = M_STOP;
               end
            end
            default: begin
               m_cyc++;
               if (m_cyc % FRAME_CLKS == BIT_CLKS) m_state = M_IDLE;
            end
         endcase
         if (load) begin
            if (m_full) begin
               exp_q.push_back(make_frame(m_l, m_r));
               m_full = 1'b0;
            end else begin
               exp_q.push_back('0);
               m_und = 1'b1;
            end
         end
         if (acc) begin
            m_l    = sif.l;
            m_r    = sif.r;
            m_full = 1'b1;
            m_acc_cnt++;
         end
      end
   end

   // ---------------- monitor / receiver ----------------
   int            mon_n        = 0;
   int            mon_cnt      = 0;
   int            mon_run_seen = 0;
   logic [FW-1:0] mon_acc      = '0;
   logic          mon_prev     = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         mon_n    = 0;
         mon_cnt  = 0;
         mon_prev = 1'b0;
      end else begin
         if (mon_run_seen != m_run_id) begin
            mon_run_seen = m_run_id;
            mon_n        = 0;
            mon_cnt      = 0;
         end
         check("in_ready", sif.ready, !m_full);
         check("busy", busy, m_state != M_IDLE);
         check("underrun", underrun, m_und);
         if (m_state == M_IDLE) begin
            check("idle_bclk", bclk, 0);
            check("idle_ws", ws, 0);
            check("idle_dout", dout, 0);
         end
         if (bclk && !mon_prev) begin
            check("rise_phase", m_cyc % BIT_CLKS, CLK_DIV);
            check("ws", ws, (mon_n % FW) >= SLOT_W);
            if (mon_n == 0) begin
               check("dout_lead", dout, 0);
            end else begin
               mon_acc = {mon_acc[FW-2:0], dout};
               mon_cnt++;
               if (mon_cnt == FW) begin
                  mon_cnt = 0;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_err++;
                     $display("FAIL frame: got %h with no frame expected", mon_acc);
                  end else begin
                     check("frame", mon_acc, exp_q.pop_front());
                  end
               end
            end
            mon_n++;
         end
         if (!bclk && mon_prev) check("fall_phase", m_cyc % BIT_CLKS, 0);
         mon_prev = bclk;
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves valid high; caller either sends again or drops valid.
   task automatic send(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                       input int budget);
      int start;
      start     = m_acc_cnt;
      sif.l     = l;
      sif.r     = r;
      sif.valid = 1'b1;
      for (int i = 0; i < budget && m_acc_cnt == start; i++) tick();
      if (m_acc_cnt == start) begin
         n_checks++;
         n_err++;
         $display("FAIL send_timeout: pair %h/%h not taken in %0d clks", l, r, budget);
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && m_state != M_IDLE; i++) tick();
      check("wait_idle", m_state == M_IDLE, 1);
   endtask

   task automatic wait_cyc(input int target, input int budget);
      for (int i = 0; i < budget && !(m_state == M_RUN && m_cyc == target); i++) tick();
      check("wait_cyc", m_cyc, target);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bclk"}, bclk, 0);
      check({tag, "_ws"}, ws, 0);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_ready"}, sif.ready, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      sif.valid = 1'b0;
      sif.l     = '0;
      sif.r     = '0;

      // 1: held in reset while inputs toggle
      for (int i = 0; i < 4; i++) begin
         tick();
         en        = ~en;
         sif.valid = ~sif.valid;
         tick();
         check_reset_vals("rst_hold");
      end
      en        = 1'b0;
      sif.valid = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // 2 + 3: one loaded frame, then two underrun frames
      send(24'hA5A5A5, 24'h123456, 10);
      sif.valid = 1'b0;
      en = 1'b1;
      repeat (3 * FRAME_CLKS) tick();
      en = 1'b0;
      wait_idle(2 * FRAME_CLKS + 10);

      // 4: three pairs streamed with valid held
      send(24'h111111, 24'hEEEEEE, 10);
      en = 1'b1;
      send(24'h222222, 24'hDDDDDD, 20);
      send(24'h333333, 24'hCCCCCC, FRAME_CLKS + 20);
      sif.valid = 1'b0;
      repeat (3 * FRAME_CLKS) tick();
      en = 1'b0;
      wait_idle(2 * FRAME_CLKS + 10);

      // 5: drop en during bit 10, expect one frame plus the trailing bit
      en = 1'b1;
      wait_cyc(10 * BIT_CLKS + 1, 20 * BIT_CLKS);
      en = 1'b0;
      wait_idle(2 * FRAME_CLKS + 10);
      check("stop_rises", mon_n, FW + 1);
      check("stop_bclk", bclk, 0);

      // 6: accept coincides with a load from an empty buffer
      en = 1'b1;
      wait_cyc(FRAME_CLKS - 1, FRAME_CLKS + 10);
      send(24'hC0FFEE, 24'h0BADF0, 4);
      check("coincide_underrun", underrun, 1);
      check("coincide_ready", sif.ready, 0);
      sif.valid = 1'b0;

      // random traffic in the same run
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 300)) tick();
         send(SAMPLE_W'($urandom()), SAMPLE_W'($urandom()), 2 * FRAME_CLKS);
         if ($urandom_range(0, 3) != 0) sif.valid = 1'b0;
      end
      sif.valid = 1'b0;
      repeat (2 * FRAME_CLKS) tick();
      en = 1'b0;
      wait_idle(2 * FRAME_CLKS + 10);
      check("queue_drained", exp_q.size(), 0);

      // 1b: asynchronous reset mid-frame, inside the right slot
      send(24'h5A5A5A, 24'hA5A5A5, 10);
      sif.valid = 1'b0;
      en = 1'b1;
      repeat (40 * BIT_CLKS + 1) tick();
      check("pre_rst_ws", ws, 1);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      tick();
      tick();
      rst = 1'b0;
      repeat (4) tick();
      check_reset_vals("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
